// File: rtl/fsync_nbr_rendezvous.sv
// Neighbour-level fractal-sync rendezvous: pairs a sync request from side A with one
// from side B and answers with a one-cycle wake, or with error pulses on mismatch/duplicate/timeout.
module fsync_nbr_rendezvous #(
  parameter int unsigned NBR_AGGR_W  = 4,
  parameter int unsigned NBR_ID_W    = 4,
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_sync_i,
  input  logic [NBR_AGGR_W-1:0] a_aggr_i,
  input  logic [NBR_ID_W-1:0]   a_id_i,
  output logic                  a_wake_o,
  output logic                  a_error_o,
  output logic [NBR_ID_W-1:0]   a_id_rsp_o,
  input  logic                  b_sync_i,
  input  logic [NBR_AGGR_W-1:0] b_aggr_i,
  input  logic [NBR_ID_W-1:0]   b_id_i,
  output logic                  b_wake_o,
  output logic                  b_error_o,
  output logic [NBR_ID_W-1:0]   b_id_rsp_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, A_PEND, B_PEND} state_t;

  // Timeout fires on the edge where the count taken since entry reaches TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_t                state, state_nxt;
  logic [NBR_AGGR_W-1:0] pend_aggr, pend_aggr_nxt;
  logic [NBR_ID_W-1:0]   pend_id, pend_id_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  a_wake_nxt, a_error_nxt, b_wake_nxt, b_error_nxt;
  logic [NBR_ID_W-1:0]   id_rsp_nxt;
  logic                  ab_match, a_match_pend, b_match_pend, timeout_hit;

  assign ab_match     = (a_aggr_i == b_aggr_i) && (a_id_i == b_id_i);
  assign a_match_pend = (a_aggr_i == pend_aggr) && (a_id_i == pend_id);
  assign b_match_pend = (b_aggr_i == pend_aggr) && (b_id_i == pend_id);
  assign timeout_hit  = (TIMEOUT_CYC != 0) && (cnt >= TO_LAST);

  always_comb begin
    state_nxt     = state;
    pend_aggr_nxt = pend_aggr;
    pend_id_nxt   = pend_id;
    cnt_nxt       = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    a_wake_nxt    = 1'b0;
    a_error_nxt   = 1'b0;
    b_wake_nxt    = 1'b0;
    b_error_nxt   = 1'b0;
    id_rsp_nxt    = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (a_sync_i && b_sync_i) begin
          if (ab_match) begin
            a_wake_nxt = 1'b1;
            b_wake_nxt = 1'b1;
            id_rsp_nxt = a_id_i;
          end else begin
            a_error_nxt = 1'b1;
            b_error_nxt = 1'b1;
          end
        end else if (a_sync_i) begin
          pend_aggr_nxt = a_aggr_i;
          pend_id_nxt   = a_id_i;
          state_nxt     = A_PEND;
        end else if (b_sync_i) begin
          pend_aggr_nxt = b_aggr_i;
          pend_id_nxt   = b_id_i;
          state_nxt     = B_PEND;
        end
      end
      A_PEND: begin
        // A duplicate outranks a completing B; B's request then becomes the pending one.
        if (a_sync_i) begin
          a_error_nxt = 1'b1;
          if (b_sync_i) begin
            pend_aggr_nxt = b_aggr_i;
            pend_id_nxt   = b_id_i;
            cnt_nxt       = '0;
            state_nxt     = B_PEND;
          end else begin
            state_nxt = IDLE;
          end
        end else if (b_sync_i) begin
          if (b_match_pend) begin
            a_wake_nxt = 1'b1;
            b_wake_nxt = 1'b1;
            id_rsp_nxt = pend_id;
          end else begin
            a_error_nxt = 1'b1;
            b_error_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          a_error_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      B_PEND: begin
        if (b_sync_i) begin
          b_error_nxt = 1'b1;
          if (a_sync_i) begin
            pend_aggr_nxt = a_aggr_i;
            pend_id_nxt   = a_id_i;
            cnt_nxt       = '0;
            state_nxt     = A_PEND;
          end else begin
            state_nxt = IDLE;
          end
        end else if (a_sync_i) begin
          if (a_match_pend) begin
            a_wake_nxt = 1'b1;
            b_wake_nxt = 1'b1;
            id_rsp_nxt = pend_id;
          end else begin
            a_error_nxt = 1'b1;
            b_error_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          b_error_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      pend_aggr  <= '0;
      pend_id    <= '0;
      cnt        <= '0;
      a_wake_o   <= 1'b0;
      a_error_o  <= 1'b0;
      a_id_rsp_o <= '0;
      b_wake_o   <= 1'b0;
      b_error_o  <= 1'b0;
      b_id_rsp_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_aggr  <= pend_aggr_nxt;
      pend_id    <= pend_id_nxt;
      cnt        <= cnt_nxt;
      a_wake_o   <= a_wake_nxt;
      a_error_o  <= a_error_nxt;
      a_id_rsp_o <= id_rsp_nxt;
      b_wake_o   <= b_wake_nxt;
      b_error_o  <= b_error_nxt;
      b_id_rsp_o <= id_rsp_nxt;
      busy_o     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_fsync_nbr_rendezvous.sv
// Bench for fsync_nbr_rendezvous: two instances (timeout off and timeout 4) share directed and
// random stimulus and are compared each cycle against a request-level reference model.
module tb_fsync_nbr_rendezvous;

  localparam int AW = 2;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst, a_sync, b_sync;
  logic [AW-1:0] a_aggr, b_aggr;
  logic [IW-1:0] a_id, b_id;
  logic [1:0] a_wake, a_err, b_wake, b_err, busy;
  logic [1:0][IW-1:0] a_rsp, b_rsp;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fsync_nbr_rendezvous #(
      .NBR_AGGR_W(AW), .NBR_ID_W(IW), .TIMEOUT_CYC(g * 4), .CNT_W(8)
    ) dut (
      .clk_i(clk), .rst_i(rst),
      .a_sync_i(a_sync), .a_aggr_i(a_aggr), .a_id_i(a_id),
      .a_wake_o(a_wake[g]), .a_error_o(a_err[g]), .a_id_rsp_o(a_rsp[g]),
      .b_sync_i(b_sync), .b_aggr_i(b_aggr), .b_id_i(b_id),
      .b_wake_o(b_wake[g]), .b_error_o(b_err[g]), .b_id_rsp_o(b_rsp[g]),
      .busy_o(busy[g])
    );
  end

  int num_vectors = 0;
  int num_miscompares = 0;

  // Reference model: which side (0 none, 1 A, 2 B) holds a request, its fields and capture edge.
  int m_side [2];
  logic [AW-1:0] m_aggr [2];
  logic [IW-1:0] m_id [2];
  int m_start [2];
  int edge_n = 0;
  bit have_exp = 0;
  bit [1:0] e_a_wake, e_a_err, e_b_wake, e_b_err, e_busy;
  logic [IW-1:0] e_a_rsp [2];
  logic [IW-1:0] e_b_rsp [2];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_vectors++;
    if (observed !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Results produced at one edge become visible for the whole following cycle.
  task automatic checkModel();
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("i%0d a_wake", g), 32'(a_wake[g]), 32'(e_a_wake[g]));
      checkOutput($sformatf("i%0d a_error", g), 32'(a_err[g]), 32'(e_a_err[g]));
      checkOutput($sformatf("i%0d a_id_rsp", g), 32'(a_rsp[g]), 32'(e_a_rsp[g]));
      checkOutput($sformatf("i%0d b_wake", g), 32'(b_wake[g]), 32'(e_b_wake[g]));
      checkOutput($sformatf("i%0d b_error", g), 32'(b_err[g]), 32'(e_b_err[g]));
      checkOutput($sformatf("i%0d b_id_rsp", g), 32'(b_rsp[g]), 32'(e_b_rsp[g]));
      checkOutput($sformatf("i%0d busy", g), 32'(busy[g]), 32'(e_busy[g]));
    end
  endtask

  task automatic modelStep(input logic r, input logic as, input logic [AW-1:0] aa, input logic [IW-1:0] ai,
                           input logic bs, input logic [AW-1:0] ba, input logic [IW-1:0] bi);
    edge_n++;
    for (int g = 0; g < 2; g++) begin
      int tmo;
      tmo = g * 4;
      e_a_wake[g] = 0; e_a_err[g] = 0; e_b_wake[g] = 0; e_b_err[g] = 0;
      e_a_rsp[g] = '0; e_b_rsp[g] = '0;
      if (r) begin
        m_side[g] = 0;
      end else if (m_side[g] == 0) begin
        if (as && bs) begin
          if (aa == ba && ai == bi) begin
            e_a_wake[g] = 1; e_b_wake[g] = 1; e_a_rsp[g] = ai; e_b_rsp[g] = ai;
          end else begin
            e_a_err[g] = 1; e_b_err[g] = 1;
          end
        end else if (as) begin
          m_side[g] = 1; m_aggr[g] = aa; m_id[g] = ai; m_start[g] = edge_n;
        end else if (bs) begin
          m_side[g] = 2; m_aggr[g] = ba; m_id[g] = bi; m_start[g] = edge_n;
        end
      end else begin
        bit own, other;
        logic [AW-1:0] oa;
        logic [IW-1:0] oi;
        own   = (m_side[g] == 1) ? as : bs;
        other = (m_side[g] == 1) ? bs : as;
        oa    = (m_side[g] == 1) ? ba : aa;
        oi    = (m_side[g] == 1) ? bi : ai;
        if (own) begin
          if (m_side[g] == 1) e_a_err[g] = 1; else e_b_err[g] = 1;
          if (other) begin
            m_side[g] = 3 - m_side[g]; m_aggr[g] = oa; m_id[g] = oi; m_start[g] = edge_n;
          end else begin
            m_side[g] = 0;
          end
        end else if (other) begin
          if (oa == m_aggr[g] && oi == m_id[g]) begin
            e_a_wake[g] = 1; e_b_wake[g] = 1; e_a_rsp[g] = oi; e_b_rsp[g] = oi;
          end else begin
            e_a_err[g] = 1; e_b_err[g] = 1;
          end
          m_side[g] = 0;
        end else if (tmo > 0 && edge_n - m_start[g] >= tmo) begin
          if (m_side[g] == 1) e_a_err[g] = 1; else e_b_err[g] = 1;
          m_side[g] = 0;
        end
      end
      e_busy[g] = (m_side[g] != 0);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic as, input logic [AW-1:0] aa, input logic [IW-1:0] ai,
                               input logic bs, input logic [AW-1:0] ba, input logic [IW-1:0] bi);
    @(negedge clk);
    if (have_exp) checkModel();
    rst = r; a_sync = as; a_aggr = aa; a_id = ai; b_sync = bs; b_aggr = ba; b_id = bi;
    modelStep(r, as, aa, ai, bs, ba, bi);
    have_exp = 1;
  endtask

  task automatic idle();                    applyStimulus(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic doReset();                 applyStimulus(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic syncA(input int aa, input int ai); applyStimulus(0, 1, AW'(aa), IW'(ai), 0, 0, 0); endtask
  task automatic syncB(input int ba, input int bi); applyStimulus(0, 0, 0, 0, 1, AW'(ba), IW'(bi)); endtask

  initial begin
    rst = 1; a_sync = 0; a_aggr = '0; a_id = '0; b_sync = 0; b_aggr = '0; b_id = '0;
    for (int g = 0; g < 2; g++) begin
      m_side[g] = 0; m_aggr[g] = '0; m_id[g] = '0; m_start[g] = 0;
    end

    doReset(); doReset(); idle();
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset a_wake", 32'(a_wake), 32'h0);

    // A then B three edges later, matching fields
    syncA(1, 2); idle();
    checkOutput("pend busy", 32'(busy), 32'h3);
    idle(); syncB(1, 2); idle();
    checkOutput("match a_wake", 32'(a_wake), 32'h3);
    checkOutput("match b_wake", 32'(b_wake), 32'h3);
    checkOutput("match id_rsp", 32'(a_rsp[0]), 32'h2);
    idle();
    checkOutput("wake one cycle", 32'(a_wake), 32'h0);

    // Same-cycle mismatch
    applyStimulus(0, 1, 2'd1, 3'd1, 1, 2'd1, 3'd3); idle();
    checkOutput("mismatch a_err", 32'(a_err), 32'h3);
    checkOutput("mismatch b_err", 32'(b_err), 32'h3);
    checkOutput("mismatch busy", 32'(busy), 32'h0);

    // Duplicate A, then a clean matching pair
    syncA(0, 5); syncA(0, 5); idle();
    checkOutput("dup a_err", 32'(a_err), 32'h3);
    checkOutput("dup b_err", 32'(b_err), 32'h0);
    applyStimulus(0, 1, 2'd2, 3'd4, 1, 2'd2, 3'd4); idle();
    checkOutput("pair b_wake", 32'(b_wake), 32'h3);

    // Timeout of 4 on instance 1 only
    syncA(3, 1); idle(); idle(); idle(); idle(); idle();
    checkOutput("timeout a_err", 32'(a_err), 32'h2);
    checkOutput("timeout busy", 32'(busy), 32'h1);
    doReset();
    syncA(3, 1); idle(); idle(); idle(); syncB(3, 1); idle();
    checkOutput("late B a_wake", 32'(a_wake), 32'h3);
    checkOutput("late B a_err", 32'(a_err), 32'h0);

    // A pending, A and B together: A duplicate errors, B becomes pending
    syncA(1, 1); applyStimulus(0, 1, 2'd1, 3'd1, 1, 2'd2, 3'd6); idle();
    checkOutput("dup+B a_err", 32'(a_err), 32'h3);
    checkOutput("dup+B b_err", 32'(b_err), 32'h0);
    checkOutput("dup+B busy", 32'(busy), 32'h3);
    syncA(2, 6); idle();
    checkOutput("B_PEND match rsp", 32'(b_rsp[1]), 32'h6);

    // Reset while B is pending drops it silently
    syncB(0, 0); doReset(); idle();
    checkOutput("rst pend busy", 32'(busy), 32'h0);
    checkOutput("rst pend b_err", 32'(b_err), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 9) < 4), AW'($urandom), IW'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) < 4), AW'($urandom), IW'($urandom_range(0, 1)));
    end
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule

// File: doc/fsync_nbr_rendezvous.md
# fsync_nbr_rendezvous

Neighbour-level fractal-sync node that sits directly downstream of the per-tile memory-mapped fsync controllers on the horizontal-neighbour and vertical-neighbour links. One instance joins two adjacent tiles, side A and side B. It captures each side's sync request and, once both sides have requested with identical aggregate and id fields, returns a one-cycle wake to both. Mismatches, duplicate requests and optional timeouts are reported as one-cycle error pulses, which the controllers see on their link error lines.

## Interface
Parameters:
- NBR_AGGR_W, default magia_tile_pkg::FSYNC_NBR_AGGR_W: width of the aggr field.
- NBR_ID_W, default magia_tile_pkg::FSYNC_NBR_ID_W: width of the id field.
- TIMEOUT_CYC, default 0: cycles a half-rendezvous may stay pending before it errors. 0 disables the timeout.
- CNT_W, default 16: width of the timeout counter. TIMEOUT_CYC must be less than 2^CNT_W.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset, synchronous, active-high.
- a_sync_i, input, 1: side-A request pulse, one cycle.
- a_aggr_i, input, NBR_AGGR_W: side-A aggr, sampled when a_sync_i=1.
- a_id_i, input, NBR_ID_W: side-A id, sampled when a_sync_i=1.
- a_wake_o, output, 1: side-A wake pulse.
- a_error_o, output, 1: side-A error pulse.
- a_id_rsp_o, output, NBR_ID_W: matched id. Valid only while a_wake_o=1, otherwise 0.
- b_sync_i, b_aggr_i, b_id_i, b_wake_o, b_error_o, b_id_rsp_o: side-B equivalents, same widths and rules.
- busy_o, output, 1: high while a half-rendezvous is pending.

## Operation
State machine states:
- IDLE
- A_PEND: A's request is captured, waiting for B.
- B_PEND: B's request is captured, waiting for A.

Stored content:
- Registers pend_aggr and pend_id hold the captured request.
- A "match" means the incoming aggr and id are bitwise equal to the compared request, full width.

IDLE transitions:
- Neither side syncs: stay in IDLE.
- Only A syncs: capture A's aggr and id, go to A_PEND.
- Only B syncs: capture B's aggr and id, go to B_PEND.
- Both sync in the same cycle, fields match: wake both sides, with a/b_id_rsp_o = id. Stay in IDLE.
- Both sync in the same cycle, fields differ: error both sides. Stay in IDLE.

A_PEND transitions (B_PEND is symmetric):
- B syncs alone, match: wake both sides, go to IDLE.
- B syncs alone, mismatch: error both sides, go to IDLE.
- A syncs again alone (duplicate): error A only, discard the pending request, go to IDLE.
- A and B sync in the same cycle: the duplicate takes priority. Error A, drop A's pending request, capture B's request, go to B_PEND. B gets no pulse.
- Timeout counter reaches TIMEOUT_CYC (only when TIMEOUT_CYC>0): error A, go to IDLE.
  - A sync from the other side in that same cycle takes priority over the timeout.

Timeout counter:
- Cleared on entry to A_PEND or B_PEND.
- Increments once per cycle while pending.
- Saturates and does not wrap.

Output rules:
- All outputs are registered.
- Wake and error pulses last exactly one cycle.
- A side never sees wake and error in the same cycle.
- busy_o = (state != IDLE).

## Timing
- Reset: rst_i=1 at a clock edge forces state IDLE, clears the counter, pend_aggr and pend_id, and drives every output to 0.
  - Reset mid-rendezvous silently drops the pending request. No error is emitted.
  - Syncs in the reset cycle are ignored.
- Latency: a completing sync sampled at edge t produces wake/error/id_rsp visible in cycle t+1, deasserted at t+2.
- A new sync sampled at t+1 is accepted normally. Back-to-back rendezvous can run every cycle.
- Timeout: pending entered at edge t, with no further sync, gives the error pulse in cycle t+TIMEOUT_CYC+1.
- A sync is a level sampled on each edge. Holding it high for 2 cycles counts as two requests, so the second one is a duplicate and errors.

## Test plan
- After reset: A sync with aggr=1, id=2, then B sync 3 cycles later with aggr=1, id=2 -> a_wake_o and b_wake_o both high for 1 cycle, one cycle after B's sync; id_rsp=2; busy_o high for 3 cycles before that.
- Same-cycle syncs, A id=1 and B id=3 -> a_error_o and b_error_o high for 1 cycle, no wake, busy_o stays 0.
- A sync, then A sync again -> a_error_o only, b outputs stay 0, state returns to IDLE; a following A+B matching pair then wakes both normally.
- TIMEOUT_CYC=4, A sync alone at edge t -> a_error_o in cycle t+5. With B syncing at the 4th edge after t instead -> wakes, no error.
- A_PEND with A and B syncing in the same cycle -> a_error_o pulse, busy_o stays high (B_PEND); a later matching A -> both wake.
- rst_i asserted while in B_PEND -> all outputs 0, busy_o 0 on the next cycle, and no pulses emitted.
